// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and types for the LED fader
package led_pkg;
    localparam int          LED_COUNT         = 6;
    localparam logic [15:0] MMIO_LED_ADDR     = 16'hf000;
    localparam logic [15:0] MMIO_LED_MAX_ADDR = 16'hf001;

    typedef logic [LED_COUNT-1:0] led_vec_t;
endpackage

// File: rtl/led_fader_channel.sv
// rtl/led_fader_channel.sv - one LED: brightness level ramp and PWM compare
module led_fader_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic                req,
    input  logic [PWM_BITS-1:0] max_level,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                on
);
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] target;

    assign target = req ? max_level : '0;

    // One LSB per tick toward the target; reversal simply changes direction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level <= '0;
        end else if (tick) begin
            if (level < target) begin
                level <= level + 1'b1;
            end else if (level > target) begin
                level <= level - 1'b1;
            end
        end
    end

    assign on = (level > pwm_cnt);
endmodule

// File: rtl/led_fader.sv
// rtl/led_fader.sv - PWM LED fader top; LED_FADER_ACTIVE_LOW_EN inverts pad drive
module led_fader
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] mmio_addr,
    input  logic [7:0]  mmio_data,
    input  led_vec_t    led_in,
    output led_vec_t    led_out
);
    localparam int                 PRESC_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRESC_W-1:0]  presc;
    logic [PWM_BITS-1:0] max_level;
    logic                tick;
    led_vec_t            on;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            presc   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            presc   <= tick ? '0 : presc + 1'b1;
        end
    end

    // Channels see the pre-write max on a coinciding tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            max_level <= '1;
        end else if (mmio_addr == MMIO_LED_MAX_ADDR) begin
            max_level <= mmio_data[PWM_BITS-1:0];
        end
    end

    for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
        led_fader_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .tick      (tick),
            .req       (led_in[i]),
            .max_level (max_level),
            .pwm_cnt   (pwm_cnt),
            .on        (on[i])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
`ifdef LED_FADER_ACTIVE_LOW_EN
            led_out <= '1;
`else
            led_out <= '0;
`endif
        end else begin
`ifdef LED_FADER_ACTIVE_LOW_EN
            led_out <= ~on;
`else
            led_out <= on;
`endif
        end
    end
endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - randomized model-checked bench for led_fader
module tb_led_fader;
    localparam int NLEV = 16;
`ifdef LED_FADER_ACTIVE_LOW_EN
    localparam logic [5:0] OFF = 6'h3F;
    localparam logic       ON  = 1'b0;
`else
    localparam logic [5:0] OFF = 6'h00;
    localparam logic       ON  = 1'b1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] mmio_addr;
    logic [7:0]  mmio_data;
    logic [5:0]  led_in;
    logic [5:0]  led_out_a;
    logic [5:0]  led_out_b;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    led_fader #(.PWM_BITS(4), .STEP_DIV(2)) dut_a (
        .clock(clock), .reset(reset), .mmio_addr(mmio_addr),
        .mmio_data(mmio_data), .led_in(led_in), .led_out(led_out_a)
    );
    led_fader #(.PWM_BITS(4), .STEP_DIV(1)) dut_b (
        .clock(clock), .reset(reset), .mmio_addr(mmio_addr),
        .mmio_data(mmio_data), .led_in(led_in), .led_out(led_out_b)
    );

    always #5 clock = ~clock;

    // Reference: brightness per LED, max, and cycles since reset (pwm phase = cyc mod 16).
    int         m_level [2][6];
    int         m_max   [2] = '{15, 15};
    int         m_cyc   [2] = '{0, 0};
    logic [5:0] m_out   [2] = '{OFF, OFF};

    function automatic int step_div(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic logic [5:0] drive(input int k);
        logic [5:0] v;
        for (int i = 0; i < 6; i++) v[i] = (m_level[k][i] > (m_cyc[k] % NLEV));
        return (ON == 1'b1) ? v : ~v;
    endfunction

    always @(posedge clock or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 6; i++) m_level[k][i] = 0;
                m_max[k] = 15;
                m_cyc[k] = 0;
                m_out[k] = OFF;
            end else begin
                m_out[k] = drive(k);
                if (m_cyc[k] % step_div(k) == step_div(k) - 1) begin
                    for (int i = 0; i < 6; i++) begin
                        int tgt;
                        tgt = led_in[i] ? m_max[k] : 0;
                        if (m_level[k][i] < tgt) m_level[k][i]++;
                        else if (m_level[k][i] > tgt) m_level[k][i]--;
                    end
                end
                if (mmio_addr == 16'hf001) m_max[k] = int'(mmio_data[3:0]);
                m_cyc[k]++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (armed) begin
            check("led_out_div2", 32'(led_out_a), 32'(m_out[0]));
            check("led_out_div1", 32'(led_out_b), 32'(m_out[1]));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        mmio_addr = a;
        mmio_data = d;
        @(negedge clock);
        mmio_addr = 16'h0000;
    endtask

    task automatic duty(input int n, input int ch, output int hi, output int phase);
        hi = 0;
        phase = -1;
        repeat (n) begin
            @(negedge clock);
            #1;
            if (led_out_a[ch] == ON) begin
                hi++;
                phase = m_cyc[0] % NLEV;
            end
        end
    endtask

    initial begin
        int hi;
        int ph;
        reset     = 1'b1;
        led_in    = 6'h3F;
        mmio_addr = 16'h0000;
        mmio_data = 8'h00;
        cycles(3);
        armed = 1'b1;
        #1;
        check("reset_led_out", 32'(led_out_a), 32'(OFF));
        check("reset_level", 32'(m_level[0][0]), 32'd0);

        // Ramp up LED0 to full scale.
        led_in = 6'b000001;
        @(negedge clock);
        reset = 1'b0;
        cycles(29);
        check("ramp_level_29", 32'(m_level[0][0]), 32'd14);
        cycles(1);
        check("ramp_level_30", 32'(m_level[0][0]), 32'd15);
        duty(16, 0, hi, ph);
        check("duty_full", 32'(hi), 32'd15);
        check("others_dark", 32'(led_out_a[5:1]), 32'(OFF[5:1]));

        // Reverse mid-ramp.
        led_in = 6'b000000;
        cycles(18);
        led_in = 6'b000001;
        cycles(6);
        led_in = 6'b000000;
        cycles(30);
        check("reversal_dark", 32'(m_level[0][0]), 32'd0);

        // Lower max while lit; wrong address ignored.
        led_in = 6'b000001;
        cycles(40);
        write(16'hf001, 8'h05);
        cycles(24);
        duty(16, 0, hi, ph);
        check("duty_max5", 32'(hi), 32'd5);
        write(16'hf000, 8'h0A);
        cycles(40);
        duty(16, 0, hi, ph);
        check("duty_max5_after_f000", 32'(hi), 32'd5);

        // Level 0 never lights.
        led_in = 6'b000000;
        cycles(20);
        duty(64, 0, hi, ph);
        check("duty_zero", 32'(hi), 32'd0);

        // Max 1: one pulse per period, one cycle after pwm phase 0.
        write(16'hf001, 8'h01);
        led_in = 6'b000001;
        cycles(10);
        duty(16, 0, hi, ph);
        check("duty_max1", 32'(hi), 32'd1);
        check("max1_phase", 32'(ph), 32'd1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if ($urandom_range(15) == 0) led_in = 6'($urandom);
            case ($urandom_range(15))
                0, 1:    begin mmio_addr = 16'hf001; mmio_data = 8'($urandom); end
                2:       begin mmio_addr = 16'hf000; mmio_data = 8'($urandom); end
                3:       begin mmio_addr = 16'($urandom); mmio_data = 8'($urandom); end
                default: mmio_addr = 16'h0000;
            endcase
        end
        mmio_addr = 16'h0000;

        // Asynchronous reset while fully lit.
        write(16'hf001, 8'h0F);
        led_in = 6'h3F;
        cycles(40);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_a", 32'(led_out_a), 32'(OFF));
        check("async_reset_b", 32'(led_out_b), 32'(OFF));
        cycles(2);
        reset = 1'b0;
        cycles(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
